// File: rtl/mem_responder.sv
// Byte-wide memory responder: synchronous byte RAM plus an I/O window with a
// transmit FIFO, a single-entry receive holding register and a halt strobe.
module mem_responder #(
    parameter int          ADDR_WIDTH    = 17,
    parameter logic [31:0] IO_BASE       = 32'h0003_0000,
    parameter int          FIFO_DEPTH    = 8,
    parameter string       RAM_INIT_FILE = ""
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_addr,
    input  logic [7:0]  mem_write,
    input  logic        r_nw_in,
    output logic [7:0]  mem_read,
    output logic        io_buffer_full,
    output logic [7:0]  io_tx_data,
    output logic        io_tx_valid,
    input  logic        io_tx_ready,
    input  logic [7:0]  io_rx_data,
    input  logic        io_rx_valid,
    output logic        io_rx_ready,
    output logic        sim_halt
);

    localparam int               PTR_W    = $clog2(FIFO_DEPTH);
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [7:0]            ram_q [0:(1 << ADDR_WIDTH) - 1];
    logic [7:0]            fifo_q [0:FIFO_DEPTH-1];
    logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [7:0]            mem_read_q, mem_read_d;
    logic [7:0]            rx_data_q;
    logic                  rx_full_q, ovf_q, sim_halt_q;

    logic [ADDR_WIDTH-1:0] ram_idx;
    logic [31:0]           io_off;
    logic                  is_io, ram_rd, ram_wr, rx_rd, st_rd, other_rd;
    logic                  tx_wr, halt_wr, tx_full, pop, push_ok, rx_cap;

    // Every rdy_in cycle is a transaction; all enables fold rdy_in in here.
    assign ram_idx  = mem_addr[ADDR_WIDTH-1:0];
    assign is_io    = (mem_addr >= IO_BASE);
    assign io_off   = mem_addr - IO_BASE;
    assign ram_rd   = rdy_in && !is_io && r_nw_in;
    assign ram_wr   = rdy_in && !is_io && !r_nw_in;
    assign rx_rd    = rdy_in && is_io && r_nw_in && (io_off == 32'd0);
    assign st_rd    = rdy_in && is_io && r_nw_in && (io_off == 32'd4);
    assign other_rd = rdy_in && is_io && r_nw_in && (io_off != 32'd0) && (io_off != 32'd4);
    assign tx_wr    = rdy_in && is_io && !r_nw_in && (io_off == 32'd0);
    assign halt_wr  = rdy_in && is_io && !r_nw_in && (io_off == 32'd4);

    assign tx_full  = (count_q == FULL_CNT);
    assign pop      = io_tx_valid && io_tx_ready;
    // Push is judged on the pre-edge count, so a full FIFO drops it even with a pop.
    assign push_ok  = tx_wr && !tx_full;
    assign rx_cap   = rdy_in && io_rx_valid && !rx_full_q;

    assign io_buffer_full = tx_full;
    assign io_tx_valid    = (count_q != '0) && rdy_in;
    assign io_tx_data     = fifo_q[rd_ptr_q];
    assign io_rx_ready    = !rx_full_q;
    assign mem_read       = mem_read_q;
    assign sim_halt       = sim_halt_q;

    always_comb begin
        mem_read_d = mem_read_q;
        if (ram_rd) begin
            mem_read_d = ram_q[ram_idx];
        end else if (rx_rd) begin
            mem_read_d = rx_full_q ? rx_data_q : 8'h00;
        end else if (st_rd) begin
            mem_read_d = {5'b0, ovf_q, rx_full_q, tx_full};
        end else if (other_rd) begin
            mem_read_d = 8'h00;
        end
    end

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // RAM is not reset; a write coinciding with reset is discarded.
    always_ff @(posedge clk_in) begin
        if (ram_wr && rst_in) begin
            ram_q[ram_idx] <= mem_write;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            mem_read_q <= 8'h00;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            rx_full_q  <= 1'b0;
            rx_data_q  <= 8'h00;
            ovf_q      <= 1'b0;
            sim_halt_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= 8'h00;
            end
        end else begin
            mem_read_q <= mem_read_d;
            count_q    <= count_d;
            sim_halt_q <= halt_wr;
            if (push_ok) begin
                fifo_q[wr_ptr_q] <= mem_write;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (tx_wr && tx_full) begin
                ovf_q <= 1'b1;
            end
            if (rx_cap) begin
                rx_full_q <= 1'b1;
                rx_data_q <= io_rx_data;
            end else if (rx_rd) begin
                rx_full_q <= 1'b0;
            end
        end
    end

endmodule
